// File: rtl/matmul_scheduler.sv
// ---------------------------------------------------------------------------
// matmul_scheduler
//
// Sequencing controller for a four-lane shared data memory. A start request
// runs a complete DIM x DIM integer matrix multiply C = A * B held in a
// 256 x 16 RAM. Lane L handles row i = 4*pass + L, and all lanes step in
// lockstep under one FSM. Each lane keeps a 16-bit accumulator, and all
// arithmetic wraps modulo 2^16. The host/file port of the RAM is not driven
// here, so the host must stay off the RAM while busy is high.
//
// Parameters
//   DIM     matrix dimension, 4 or 8 (a multiple of the lane count)
//   A_BASE  word address of A[0][0], row-major
//   B_BASE  word address of B[0][0], row-major
//   C_BASE  word address of C[0][0], row-major
//
// Ports
//   clock           rising-edge clock
//   reset           synchronous, active-high reset
//   start           multiply request, sampled only in IDLE
//   busy            high while a multiply is in progress
//   done            one-cycle completion pulse
//   write_en0..3    per-lane RAM write enable
//   addr0..3        per-lane RAM address
//   datain0..3      per-lane RAM write data
//   dataout0..3     per-lane RAM read data (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; memory-side outputs are all 0
// FETCH_A | read A[i][k] on every lane
// FETCH_B | read B[k][j] (shared address); latch A element into a_reg
// MAC     | acc += a_reg * B element; advance k or go write
// WRITE   | write acc to C[i][j]; clear acc and k; advance j / pass
// DONE    | done pulse, busy low; back to IDLE next cycle
//
module matmul_scheduler #(
   parameter int DIM    = 4,
   parameter int A_BASE = 0,
   parameter int B_BASE = 64,
   parameter int C_BASE = 128
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        write_en0,
   output logic        write_en1,
   output logic        write_en2,
   output logic        write_en3,
   output logic [7:0]  addr0,
   output logic [7:0]  addr1,
   output logic [7:0]  addr2,
   output logic [7:0]  addr3,
   output logic [15:0] datain0,
   output logic [15:0] datain1,
   output logic [15:0] datain2,
   output logic [15:0] datain3,
   input  logic [15:0] dataout0,
   input  logic [15:0] dataout1,
   input  logic [15:0] dataout2,
   input  logic [15:0] dataout3
);

   localparam int NLANE = 4;
   localparam int NPASS = DIM / NLANE;
   localparam int CW    = $clog2(DIM);
   localparam int PW    = (NPASS > 1) ? $clog2(NPASS) : 1;

   localparam logic [CW-1:0] LAST_IDX  = CW'(DIM - 1);
   localparam logic [PW-1:0] LAST_PASS = PW'(NPASS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH_A,
      S_FETCH_B,
      S_MAC,
      S_WRITE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   pass_q, pass_d;
   logic [CW-1:0]   j_q, j_d;
   logic [CW-1:0]   k_q, k_d;
   logic [15:0]     acc_q   [NLANE];
   logic [15:0]     acc_d   [NLANE];
   logic [15:0]     a_reg_q [NLANE];
   logic [15:0]     a_reg_d [NLANE];

   logic [15:0]     dout    [NLANE];
   logic            we_a    [NLANE];
   logic [7:0]      addr_a  [NLANE];
   logic [15:0]     din_a   [NLANE];

   assign dout[0] = dataout0;
   assign dout[1] = dataout1;
   assign dout[2] = dataout2;
   assign dout[3] = dataout3;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         pass_q  <= '0;
         j_q     <= '0;
         k_q     <= '0;
         for (int l = 0; l < NLANE; l++) begin
            acc_q[l]   <= '0;
            a_reg_q[l] <= '0;
         end
      end else begin
         state_q <= state_d;
         pass_q  <= pass_d;
         j_q     <= j_d;
         k_q     <= k_d;
         for (int l = 0; l < NLANE; l++) begin
            acc_q[l]   <= acc_d[l];
            a_reg_q[l] <= a_reg_d[l];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state and datapath update
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pass_d  = pass_q;
      j_d     = j_q;
      k_d     = k_q;
      for (int l = 0; l < NLANE; l++) begin
         acc_d[l]   = acc_q[l];
         a_reg_d[l] = a_reg_q[l];
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH_A;
               pass_d  = '0;
               j_d     = '0;
               k_d     = '0;
               for (int l = 0; l < NLANE; l++) begin
                  acc_d[l] = '0;
               end
            end
         end

         S_FETCH_A: begin
            state_d = S_FETCH_B;
         end

         S_FETCH_B: begin
            // RAM returns the A element requested in FETCH_A this cycle
            for (int l = 0; l < NLANE; l++) begin
               a_reg_d[l] = dout[l];
            end
            state_d = S_MAC;
         end

         S_MAC: begin
            // 16-bit context keeps only the low half of product and sum
            for (int l = 0; l < NLANE; l++) begin
               acc_d[l] = acc_q[l] + a_reg_q[l] * dout[l];
            end
            if (k_q == LAST_IDX) begin
               state_d = S_WRITE;
            end else begin
               k_d     = k_q + 1'b1;
               state_d = S_FETCH_A;
            end
         end

         S_WRITE: begin
            for (int l = 0; l < NLANE; l++) begin
               acc_d[l] = '0;
            end
            k_d = '0;
            if (j_q != LAST_IDX) begin
               j_d     = j_q + 1'b1;
               state_d = S_FETCH_A;
            end else if (pass_q != LAST_PASS) begin
               pass_d  = pass_q + 1'b1;
               j_d     = '0;
               state_d = S_FETCH_A;
            end else begin
               state_d = S_DONE;
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs: decoded from registered state only
   // ------------------------------------------------------------------
   always_comb begin
      logic [7:0] row;
      logic [7:0] b_addr;

      busy   = 1'b0;
      done   = 1'b0;
      row    = '0;
      b_addr = 8'(B_BASE) + 8'(k_q) * 8'(DIM) + 8'(j_q);
      for (int l = 0; l < NLANE; l++) begin
         we_a[l]   = 1'b0;
         addr_a[l] = '0;
         din_a[l]  = '0;
      end

      case (state_q)
         S_FETCH_A: begin
            busy = 1'b1;
            for (int l = 0; l < NLANE; l++) begin
               row       = 8'(pass_q) * 8'(NLANE) + 8'(l);
               addr_a[l] = 8'(A_BASE) + row * 8'(DIM) + 8'(k_q);
            end
         end

         // The B address stays up through MAC; sharing it across lanes is
         // harmless because it is a read
         S_FETCH_B, S_MAC: begin
            busy = 1'b1;
            for (int l = 0; l < NLANE; l++) begin
               addr_a[l] = b_addr;
            end
         end

         S_WRITE: begin
            busy = 1'b1;
            for (int l = 0; l < NLANE; l++) begin
               row       = 8'(pass_q) * 8'(NLANE) + 8'(l);
               we_a[l]   = 1'b1;
               addr_a[l] = 8'(C_BASE) + row * 8'(DIM) + 8'(j_q);
               din_a[l]  = acc_q[l];
            end
         end

         S_DONE: begin
            done = 1'b1;
         end

         default: begin
         end
      endcase
   end

   assign write_en0 = we_a[0];
   assign write_en1 = we_a[1];
   assign write_en2 = we_a[2];
   assign write_en3 = we_a[3];
   assign addr0     = addr_a[0];
   assign addr1     = addr_a[1];
   assign addr2     = addr_a[2];
   assign addr3     = addr_a[3];
   assign datain0   = din_a[0];
   assign datain1   = din_a[1];
   assign datain2   = din_a[2];
   assign datain3   = din_a[3];

endmodule
